// File: rtl/pe_out_collector_pkg.sv
// Shared constants and FSM encoding for the PE output collector.
// Default widths mirror the array-wide PE_NUM / DATA_WIDTH settings.
package pe_out_collector_pkg;

    localparam int PE_NUM_DEF     = 8;
    localparam int DATA_WIDTH_DEF = 16;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    function automatic int word_w(input int dw);
        return 2 * dw;
    endfunction

endpackage

// File: rtl/pe_out_collector_lane_pick.sv
// Lowest-set-bit finder over the pending-lane mask.
// Returns the lane index and whether any lane is pending.
module pe_out_collector_lane_pick #(
    parameter int N  = 8,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_mask,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    always_comb begin
        o_idx = '0;
        o_any = |i_mask;
        // Scan downward so the lowest set bit wins.
        for (int i = N - 1; i >= 0; i--) begin
            if (i_mask[i]) begin
                o_idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/pe_out_collector.sv
// Snapshots one result word per PE lane on load and serialises the
// valid lanes, lowest index first, onto a valid/ready output stream.
module pe_out_collector
    import pe_out_collector_pkg::*;
#(
    parameter int PE_NUM     = PE_NUM_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load,
    input  logic [PE_NUM-1:0]            p_in_v,
    input  logic [PE_NUM*2*DATA_WIDTH-1:0] p_in,
    input  logic                         s_out_rdy,
    output logic                         s_out_v,
    output logic [2*DATA_WIDTH-1:0]      s_out,
    output logic                         s_out_last,
    output logic                         busy,
    output logic                         drop
);

    localparam int W  = word_w(DATA_WIDTH);
    localparam int IW = (PE_NUM > 1) ? $clog2(PE_NUM) : 1;

    state_t            r_state;
    logic [PE_NUM-1:0] r_mask;
    logic [W-1:0]      r_shadow [PE_NUM];
    logic              r_v;
    logic [W-1:0]      r_data;
    logic              r_last;
    logic              r_drop;

    logic [IW-1:0]     w_idx;
    logic              w_any;
    logic [PE_NUM-1:0] w_onehot;
    logic [PE_NUM-1:0] w_mask_nxt;
    logic              w_free;
    logic              w_hs;

    pe_out_collector_lane_pick #(
        .N  (PE_NUM),
        .IW (IW)
    ) u_lane_pick (
        .i_mask (r_mask),
        .o_idx  (w_idx),
        .o_any  (w_any)
    );

    assign w_onehot   = PE_NUM'(1) << w_idx;
    assign w_mask_nxt = r_mask & ~w_onehot;
    assign w_free     = !r_v || s_out_rdy;
    assign w_hs       = r_v && s_out_rdy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_mask  <= '0;
            r_v     <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
            r_drop  <= 1'b0;
            for (int i = 0; i < PE_NUM; i++) begin
                r_shadow[i] <= '0;
            end
        end else begin
            r_drop <= load && (r_state == ST_SHIFT);
            unique case (r_state)
                ST_IDLE: begin
                    if (load && (|p_in_v)) begin
                        for (int i = 0; i < PE_NUM; i++) begin
                            r_shadow[i] <= p_in[i*W +: W];
                        end
                        r_mask  <= p_in_v;
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (w_hs && r_last) begin
                        r_state <= ST_IDLE;
                    end
                    // A stalled word keeps its slot until accepted.
                    if (w_free) begin
                        if (w_any) begin
                            r_data <= r_shadow[w_idx];
                            r_v    <= 1'b1;
                            r_mask <= w_mask_nxt;
                            r_last <= (w_mask_nxt == '0);
                        end else begin
                            r_v    <= 1'b0;
                            r_data <= '0;
                            r_last <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_out_v    = r_v;
    assign s_out      = r_data;
    assign s_out_last = r_last;
    assign busy       = (r_state == ST_SHIFT);
    assign drop       = r_drop;

endmodule
